// File: rtl/px_write_scheduler.sv
// Frame-buffer write-port scheduler: grants full-screen clears and horizontal-run draws,
// then expands the granted command into one registered pixel write per clock.
module px_write_scheduler #(
   parameter int AW    = 15,
   parameter int DW    = 3,
   parameter int SCR_W = 128,
   parameter int SCR_H = 96
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_req,
   input  logic [DW-1:0]   clr_color,
   output logic            clr_ack,
   input  logic [1:0]      run_req,
   input  logic [15:0]     run_x,
   input  logic [13:0]     run_y,
   input  logic [15:0]     run_len,
   input  logic [2*DW-1:0] run_color,
   output logic [1:0]      run_ack,
   output logic [AW-1:0]   mem_px_addr,
   output logic [DW-1:0]   mem_px_data,
   output logic            px_wr,
   output logic            busy,
   output logic            done
);

   localparam int               NPIX     = SCR_W * SCR_H;
   localparam int               CNT_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
   localparam logic [15:0]      SCR_W16  = 16'(SCR_W);
   localparam logic [15:0]      SCR_H16  = 16'(SCR_H);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN
   } state_t;

   state_t           r_state,   w_state_nxt;
   logic [CNT_W-1:0] r_remain,  w_remain_nxt;
   logic             r_rr_ptr,  w_rr_nxt;
   logic [AW-1:0]    r_addr,    w_addr_nxt;
   logic [DW-1:0]    r_data,    w_data_nxt;
   logic             r_px_wr,   w_px_wr_nxt;
   logic             r_busy,    w_busy_nxt;
   logic             r_done,    w_done_nxt;
   logic             r_clr_ack, w_clr_ack_nxt;
   logic [1:0]       r_run_ack, w_run_ack_nxt;

   logic             w_run_sel;
   logic [7:0]       w_sel_x;
   logic [6:0]       w_sel_y;
   logic [7:0]       w_sel_len;
   logic [DW-1:0]    w_sel_color;
   logic             w_sel_vis;
   logic [15:0]      w_room;
   logic [15:0]      w_npix;
   logic [AW-1:0]    w_base;

   // With both requesting the pointer decides; otherwise the lone requester wins.
   assign w_run_sel   = (run_req == 2'b11) ? r_rr_ptr : run_req[1];
   assign w_sel_x     = w_run_sel ? run_x[15:8]            : run_x[7:0];
   assign w_sel_y     = w_run_sel ? run_y[13:7]            : run_y[6:0];
   assign w_sel_len   = w_run_sel ? run_len[15:8]          : run_len[7:0];
   assign w_sel_color = w_run_sel ? run_color[2*DW-1:DW]   : run_color[DW-1:0];

   // Column arithmetic is 16 bits wide so x near 255 can never alias back on screen.
   assign w_sel_vis = (16'(w_sel_x) < SCR_W16) && (16'(w_sel_y) < SCR_H16) &&
                      (w_sel_len != 8'd0);
   assign w_room    = SCR_W16 - 16'(w_sel_x);
   assign w_npix    = (16'(w_sel_len) < w_room) ? 16'(w_sel_len) : w_room;
   assign w_base    = AW'(w_sel_y) * AW'(SCR_W) + AW'(w_sel_x);

   // NOTE: every state register is written with <= so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_remain  <= '0;
         r_rr_ptr  <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_px_wr   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_clr_ack <= 1'b0;
         r_run_ack <= 2'b00;
      end else begin
         r_state   <= w_state_nxt;
         r_remain  <= w_remain_nxt;
         r_rr_ptr  <= w_rr_nxt;
         r_addr    <= w_addr_nxt;
         r_data    <= w_data_nxt;
         r_px_wr   <= w_px_wr_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_clr_ack <= w_clr_ack_nxt;
         r_run_ack <= w_run_ack_nxt;
      end
   end

   // NOTE: each signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt   = r_state;
      w_remain_nxt  = r_remain;
      w_rr_nxt      = r_rr_ptr;
      w_addr_nxt    = r_addr;
      w_data_nxt    = r_data;
      w_px_wr_nxt   = 1'b0;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = 1'b0;
      w_clr_ack_nxt = 1'b0;
      w_run_ack_nxt = 2'b00;

      case (r_state)
         IDLE: begin
            if (clr_req) begin
               w_state_nxt   = CLEAR;
               w_clr_ack_nxt = 1'b1;
               w_busy_nxt    = 1'b1;
               w_px_wr_nxt   = 1'b1;
               w_addr_nxt    = '0;
               w_data_nxt    = clr_color;
               w_remain_nxt  = LAST_PIX;
            end else if (run_req != 2'b00) begin
               w_state_nxt   = RUN;
               w_busy_nxt    = 1'b1;
               w_rr_nxt      = ~w_run_sel;
               w_run_ack_nxt = w_run_sel ? 2'b10 : 2'b01;
               w_remain_nxt  = '0;
               // Off-screen or empty runs still spend one busy cycle, but write nothing.
               if (w_sel_vis) begin
                  w_px_wr_nxt  = 1'b1;
                  w_addr_nxt   = w_base;
                  w_data_nxt   = w_sel_color;
                  w_remain_nxt = CNT_W'(w_npix - 16'd1);
               end
            end
         end

         CLEAR, RUN: begin
            if (r_remain == '0) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_remain_nxt = r_remain - CNT_W'(1);
               w_addr_nxt   = r_addr + AW'(1);
               w_px_wr_nxt  = 1'b1;
               w_busy_nxt   = 1'b1;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   assign clr_ack     = r_clr_ack;
   assign run_ack     = r_run_ack;
   assign mem_px_addr = r_addr;
   assign mem_px_data = r_data;
   assign px_wr       = r_px_wr;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_px_write_scheduler.sv
// Self-checking bench for px_write_scheduler: directed cases plus randomized requests
// checked cycle by cycle against a transaction-level model of grants and pixel writes.
module tb_px_write_scheduler;

   localparam int AW    = 15;
   localparam int DW    = 3;
   localparam int SCR_W = 128;
   localparam int SCR_H = 96;
   localparam int NPIX  = SCR_W * SCR_H;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            clr_req = 1'b0;
   logic [DW-1:0]   clr_color = '0;
   logic            clr_ack;
   logic [1:0]      run_req = 2'b00;
   logic [15:0]     run_x = '0;
   logic [13:0]     run_y = '0;
   logic [15:0]     run_len = '0;
   logic [2*DW-1:0] run_color = '0;
   logic [1:0]      run_ack;
   logic [AW-1:0]   mem_px_addr;
   logic [DW-1:0]   mem_px_data;
   logic            px_wr;
   logic            busy;
   logic            done;

   px_write_scheduler #(
      .AW(AW), .DW(DW), .SCR_W(SCR_W), .SCR_H(SCR_H)
   ) dut (
      .clk(clk), .rst(rst),
      .clr_req(clr_req), .clr_color(clr_color), .clr_ack(clr_ack),
      .run_req(run_req), .run_x(run_x), .run_y(run_y), .run_len(run_len),
      .run_color(run_color), .run_ack(run_ack),
      .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
      .px_wr(px_wr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Requester-side state and the reference model
   int         rq_x[2], rq_y[2], rq_len[2], rq_col[2];
   logic [1:0] pend = 2'b00;
   bit         hold_mode = 1'b0;
   int         m_ptr = 0;
   int         last_addr = 0;
   int         last_data = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({clr_ack, run_ack, px_wr, busy, done, mem_px_addr, mem_px_data});
   endfunction

   task automatic apply_inputs();
      run_req   = pend;
      run_x     = {rq_x[1][7:0], rq_x[0][7:0]};
      run_y     = {rq_y[1][6:0], rq_y[0][6:0]};
      run_len   = {rq_len[1][7:0], rq_len[0][7:0]};
      run_color = {rq_col[1][DW-1:0], rq_col[0][DW-1:0]};
   endtask

   task automatic set_fields(input int i, input int x, input int y, input int len, input int col);
      rq_x[i]   = x;
      rq_y[i]   = y;
      rq_len[i] = len;
      rq_col[i] = col;
   endtask

   task automatic rand_fields(input int i, input bit unit_len);
      case ($urandom_range(0, 3))
         0:       rq_x[i] = int'($urandom_range(0, 255));
         1:       rq_x[i] = int'($urandom_range(110, 135));
         2:       rq_x[i] = int'($urandom_range(0, 127));
         default: rq_x[i] = int'($urandom_range(120, 127));
      endcase
      rq_y[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                            : int'($urandom_range(0, 95));
      if (unit_len) rq_len[i] = 1;
      else rq_len[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                   : int'($urandom_range(0, 12));
      rq_col[i] = int'($urandom_range(0, 7));
   endtask

   task automatic model_reset();
      m_ptr     = 0;
      last_addr = 0;
      last_data = 0;
   endtask

   // Inputs must already be valid for the coming edge, with the DUT idle.
   // Follows one command from its ack cycle to its done cycle.
   task automatic do_cmd(input int clr_at, output int g, output int nw);
      bit         is_clr;
      int         n, base, dval, ncyc;
      logic [5:0] st_exp;
      g = -1; nw = 0; n = 0; base = 0; dval = 0;
      if (clr_req) begin
         is_clr = 1'b1;
         n      = NPIX;
         dval   = int'(clr_color);
      end else begin
         is_clr = 1'b0;
         g      = (pend == 2'b11) ? m_ptr : (pend[1] ? 1 : 0);
         m_ptr  = 1 - g;
         if (rq_y[g] < SCR_H)
            for (int j = 0; j < rq_len[g]; j++) begin
               if (rq_x[g] + j >= SCR_W) break;
               n++;
            end
         base = rq_y[g] * SCR_W + rq_x[g];
         dval = rq_col[g];
      end
      ncyc = (n == 0) ? 1 : n;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         st_exp = {c == 0 && is_clr, c == 0 && !is_clr && g == 1,
                   c == 0 && !is_clr && g == 0, 1'b1, 1'b0, n > 0};
         check("status", 32'({clr_ack, run_ack, busy, done, px_wr}), 32'(st_exp));
         if (px_wr) nw++;
         if (n > 0) begin
            check("pixel", 32'({mem_px_addr, mem_px_data}), 32'({AW'(base + c), DW'(dval)}));
            last_addr = base + c;
            last_data = dval;
         end else begin
            check("hold", 32'({mem_px_addr, mem_px_data}), 32'({AW'(last_addr), DW'(last_data)}));
         end
         if (c == 0) begin
            if (is_clr)         clr_req = 1'b0;
            else if (hold_mode) rand_fields(g, 1'b1);
            else                pend[g] = 1'b0;
         end
         if (c == clr_at) begin
            clr_req   = 1'b1;
            clr_color = 3'd5;
         end
         apply_inputs();
      end
      @(negedge clk);
      check("done", 32'({clr_ack, run_ack, busy, done, px_wr}), 32'(6'b000010));
      check("done_hold", 32'({mem_px_addr, mem_px_data}), 32'({AW'(last_addr), DW'(last_data)}));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int g, nw;
      for (int i = 0; i < 2; i++) set_fields(i, 0, 0, 0, 0);
      apply_inputs();

      #1 rst = 1'b1;
      #1 check("reset_outputs", outs(), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", outs(), 32'd0);

      // Clear beats both run requests; then requester 0, then the clipped requester 1
      set_fields(0, 64, 90, 3, 2);
      set_fields(1, 126, 0, 5, 6);
      pend = 2'b11; clr_req = 1'b1; clr_color = 3'd0;
      apply_inputs();
      do_cmd(-1, g, nw);
      check("clear_writes", 32'(nw), 32'(NPIX));
      do_cmd(-1, g, nw);
      check("run0_after_clear", 32'(g), 32'd0);
      check("run0_writes", 32'(nw), 32'd3);
      do_cmd(-1, g, nw);
      check("clip_req", 32'(g), 32'd1);
      check("clip_writes", 32'(nw), 32'd2);

      // Off-screen and empty runs
      set_fields(0, 5, 96, 4, 1);  pend = 2'b01; apply_inputs(); do_cmd(-1, g, nw);
      check("rej_y_writes", 32'(nw), 32'd0);
      set_fields(0, 200, 3, 1, 1); pend = 2'b01; apply_inputs(); do_cmd(-1, g, nw);
      check("rej_x_writes", 32'(nw), 32'd0);
      set_fields(0, 5, 3, 0, 1);   pend = 2'b01; apply_inputs(); do_cmd(-1, g, nw);
      check("rej_len_writes", 32'(nw), 32'd0);

      // Clear raised mid-run waits for the run to finish
      set_fields(0, 0, 10, 100, 4); pend = 2'b01; apply_inputs();
      do_cmd(40, g, nw);
      check("run_uninterrupted", 32'(nw), 32'd100);
      do_cmd(-1, g, nw);
      check("late_clear_writes", 32'(nw), 32'(NPIX));

      // Asynchronous reset in the middle of a long run
      set_fields(0, 0, 20, 128, 6); pend = 2'b01; apply_inputs();
      @(negedge clk);
      check("long_ack", 32'(run_ack), 32'(2'b01));
      pend = 2'b00; apply_inputs();
      repeat ($urandom_range(3, 60)) @(negedge clk);
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1 check("async_reset", outs(), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      set_fields(1, 10, 3, 4, 7); pend = 2'b10; apply_inputs();
      do_cmd(-1, g, nw);
      check("post_reset_req1", 32'(g), 32'd1);
      check("post_reset_writes", 32'(nw), 32'd4);

      // Requester 1 alone, held: granted on every idle
      hold_mode = 1'b1;
      rand_fields(1, 1'b1); pend = 2'b10; apply_inputs();
      for (int i = 0; i < 3; i++) begin
         do_cmd(-1, g, nw);
         check("solo_req1", 32'(g), 32'd1);
      end
      hold_mode = 1'b0; pend = 2'b00; apply_inputs();

      // Both held after reset: 0,1,0,1,...
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      model_reset();
      hold_mode = 1'b1;
      rand_fields(0, 1'b1); rand_fields(1, 1'b1); pend = 2'b11; apply_inputs();
      for (int i = 0; i < 6; i++) begin
         do_cmd(-1, g, nw);
         check("rr_alternate", 32'(g), 32'(i % 2));
      end
      hold_mode = 1'b0; pend = 2'b00; apply_inputs();

      // Randomized traffic with raises and withdrawals between commands
      for (int k = 0; k < 150; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && $urandom_range(0, 9) == 0) pend[i] = 1'b0;
            else if (!pend[i] && $urandom_range(0, 1) == 1) begin
               rand_fields(i, 1'b0);
               pend[i] = 1'b1;
            end
         end
         if (pend == 2'b00) begin
            int r;
            r = int'($urandom_range(0, 1));
            rand_fields(r, 1'b0);
            pend[r] = 1'b1;
         end
         apply_inputs();
         do_cmd(-1, g, nw);
      end
      pend = 2'b00; apply_inputs();

      @(negedge clk);
      check("final_idle", 32'({busy, px_wr, done}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/px_write_scheduler.md
# px_write_scheduler

Shares the single framebuffer pixel-write port (mem_px_addr / mem_px_data / px_wr) among the game's drawing agents. It accepts horizontal-run draw commands from two requesters (paddle, ball) and full-screen clear commands. Each command is expanded into one pixel write per clock. It sits between the game FSM logic and the 128x96, 3-bit-colour frame buffer, so no two agents ever drive the write port in the same cycle.

## Interface
- AW, 15, framebuffer address width; must satisfy 2^AW >= SCR_W*SCR_H
- DW, 3, pixel colour width
- SCR_W, 128, screen width in pixels
- SCR_H, 96, screen height in pixels
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  reset, asynchronous and active-high
- clr_req  in  1  request a full-screen fill; level, held until clr_ack
- clr_color  in  DW  fill colour, sampled at grant
- clr_ack  out  1  one-cycle pulse: clear command accepted
- run_req  in  2  run request per requester i (0 = paddle, 1 = ball); level, held until run_ack[i]
- run_x  in  16  start column; requester i uses bits [8i+7:8i]
- run_y  in  14  row; requester i uses bits [7i+6:7i]
- run_len  in  16  pixel count; requester i uses bits [8i+7:8i]
- run_color  in  2*DW  run colour; requester i uses bits [DW*i+DW-1:DW*i]
- run_ack  out  2  one-cycle pulse per requester: command accepted
- mem_px_addr  out  AW  write address = y*SCR_W + x
- mem_px_data  out  DW  write data
- px_wr  out  1  write strobe; one pixel per high cycle
- busy  out  1  high while in CLEAR or RUN
- done  out  1  one-cycle pulse in the cycle after a command's last cycle

## Operation
- States: IDLE, CLEAR, RUN.
- IDLE grant priority: clr_req first, then run_req by round-robin.
  - The round-robin pointer favours the requester not granted last.
  - After reset it favours requester 0.
  - The pointer updates only on run grants.
- Command fields are sampled only at the grant edge. Requesters may change them freely after ack. Dropping req before ack withdraws the request with no side effects.
- Commands are non-preemptive. A clr_req raised during RUN waits for IDLE.
- CLEAR writes addresses 0 .. SCR_W*SCR_H-1 in ascending order, one per cycle, all with clr_color. This takes 12288 cycles at the defaults.
- RUN writes pixel j (j = 0 .. len-1) at address y*SCR_W + (x+j) with run_color.
- Clipping, decided behaviour:
  - y >= SCR_H: the command is accepted (ack) but no writes occur. The block spends one cycle in RUN.
  - The run terminates early when x+j reaches SCR_W. There is no wrap to the next row.
  - x >= SCR_W behaves like y >= SCR_H.
  - len = 0 behaves like y >= SCR_H.
- The x+j arithmetic is at least 9 bits wide, so that x=255, len=255 cannot overflow into a false in-range column.
- mem_px_addr and mem_px_data hold their last values while px_wr is low.

## Timing
- Reset (asynchronous, immediate) forces the following. Any in-flight command is discarded; there is no partial resume.
  - state = IDLE, round-robin pointer = 0.
  - mem_px_addr = 0, mem_px_data = 0.
  - px_wr = 0, clr_ack = 0, run_ack = 0, busy = 0, done = 0.
- All outputs are registered.
- Grant sequence:
  - Edge k: IDLE samples a request.
  - Cycle k+1: ack is high. If the command is visible, px_wr is also high with the first pixel's address and data.
  - Subsequent cycles: one pixel per cycle.
- A visible run of n pixels gives px_wr high for exactly n consecutive cycles, and busy high for those same n cycles.
- done pulses in the cycle after the final busy cycle. In that cycle the state is IDLE, and a new grant can be made at that edge.
- Minimum gap between the last write of one command and the first write of the next is one idle cycle.
- Simultaneous run_req[0] and run_req[1] in IDLE: the one favoured by the pointer is granted. The other is granted at the next IDLE, provided it is still requesting.

## Test plan
- Reset values: assert rst mid-run at an arbitrary phase. All outputs go to 0 the same cycle, before any clk edge. After release, the next run_req[1] alone is granted normally.
- Single run, requester 0: x=64, y=90, len=3, color=3'b010. run_ack[0] pulses, then px_wr is high for 3 cycles at addresses 11584, 11585, 11586 with data 010. done pulses on the following cycle.
- Right-edge clip, requester 1: x=126, y=0, len=5. Exactly 2 writes occur, at 126 and 127; nothing goes to 128.
- Rejected geometry: y=96, len=4, then x=200, len=1, then len=0. Each is acked with zero px_wr cycles, and each gives one busy cycle followed by done.
- Round-robin: both run_req held continuously with len=1. Grants alternate 0,1,0,1.
  - After reset, requester 0 is granted first.
  - If only requester 1 requests, it is granted on every IDLE.
- Clear priority: clr_req, run_req[0] and run_req[1] all asserted in IDLE with clr_color=3'b000.
  - clr_ack is first, then 12288 consecutive writes at addresses 0..12287.
  - run_ack[0] arrives only after done.
  - A clr_req raised mid-run does not interrupt the run.
